pipe_skid_reg: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It replaces the plain enable/clear stage flops between pipeline stages wherever back-pressure must be registered rather than combinationally propagated. It provides full throughput, a one-cycle forward latency, a registered `in_ready`, synchronous flush, and an optional stall-cycle counter.

---
 rtl/pipe_skid_reg.sv | 117 +++++++++++
 tb/tb_pipe_skid_reg.sv | 125 ++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer,
// synchronous flush and an optional stall counter (enabled by PIPE_STALL_CNT_EN).
module pipe_skid_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             main_valid_q, skid_valid_q;
    logic [WIDTH-1:0] main_data_q, skid_data_q;
    logic             in_ready_q;

    logic in_fire, out_fire;
    logic load_main_in, load_main_skid, load_skid_in;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = main_valid_q & out_ready;

    // State register; valid bits and in_ready are registered images of the next state
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q      <= EMPTY;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            main_valid_q <= (state_d != EMPTY);
            skid_valid_q <= (state_d == TWO);
            in_ready_q   <= (state_d != TWO);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (in_fire) state_d = ONE;
            ONE: begin
                if (in_fire && !out_fire)      state_d = TWO;
                else if (!in_fire && out_fire) state_d = EMPTY;
            end
            TWO:     if (out_fire) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        case (state_q)
            EMPTY: load_main_in = in_fire;
            ONE: begin
                load_main_in = in_fire & out_fire;
                load_skid_in = in_fire & ~out_fire;
            end
            TWO:     load_main_skid = out_fire;
            default: ;
        endcase
    end

    // Payload registers: hold unless loaded, so held output data stays stable
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_data_q <= RESET_VAL;
            skid_data_q <= RESET_VAL;
        end else begin
            if (load_main_in)        main_data_q <= in_data;
            else if (load_main_skid) main_data_q <= skid_data_q;
            if (load_skid_in)        skid_data_q <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign occupancy = state_q;

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturating; flush deliberately leaves the count alone
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_q <= stall_cnt_q + 1'b1;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

    logic unused_skid_valid;
    assign unused_skid_valid = skid_valid_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomized self-checking bench for pipe_skid_reg against a queue-based model.
module tb_pipe_skid_reg;

    localparam int          WIDTH = 32;
    localparam logic [31:0] RV    = 32'h0000_5A5A;
    localparam int          CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] in_data, out_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;

    pipe_skid_reg #(.WIDTH(WIDTH), .RESET_VAL(RV), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO of at most two entries
    logic [31:0] q[$];
    bit          m_ready = 1'b1;
    logic [31:0] m_head  = RV;
    int          m_cnt   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit f, input bit v, input logic [31:0] d, input bit ordy);
        bit ifire, ofire, stall;
        int exp_cnt;
        rst = r; flush = f; in_valid = v; in_data = d; out_ready = ordy;
        ifire = v && m_ready;
        ofire = (q.size() > 0) && ordy;
        stall = (q.size() > 0) && !ordy;
        @(posedge clk);
        if (r) begin
            q.delete(); m_ready = 1'b1; m_head = RV; m_cnt = 0;
        end else begin
            if (stall && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (f) begin
                q.delete(); m_ready = 1'b1; m_head = RV;
            end else begin
                if (ofire) void'(q.pop_front());
                if (ifire) q.push_back(d);
                m_ready = (q.size() < 2);
                if (q.size() > 0) m_head = q[0];
            end
        end
        @(negedge clk);
`ifdef PIPE_STALL_CNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 0;
`endif
        chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
        chk("out_data",  out_data, m_head);
        chk("in_ready",  {31'b0, in_ready}, {31'b0, m_ready});
        chk("occupancy", {30'b0, occupancy}, q.size());
        chk("stall_cnt", {28'b0, stall_cnt}, exp_cnt);
    endtask

    initial begin
        // Reset and fill
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(0, 0, 1, 32'h11, 1);
        chk("fill_data", out_data, 32'h11);
        step(0, 0, 0, 0, 1);

        // Streaming
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 1, i, 1);
            chk("stream_data", out_data, i);
        end
        step(0, 0, 0, 0, 1);

        // Skid and back-pressure
        step(0, 0, 1, 32'hA, 0);
        step(0, 0, 1, 32'hB, 0);
        step(0, 0, 1, 32'hC, 0);
        chk("skid_occ", {30'b0, occupancy}, 2);
        step(0, 0, 1, 32'hC, 1);
        chk("skid_head_b", out_data, 32'hB);
        step(0, 0, 1, 32'hC, 1);
        chk("skid_head_c", out_data, 32'hC);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Flush with a full stage and a concurrent input
        step(0, 0, 1, 32'hA, 0);
        step(0, 0, 1, 32'hB, 0);
        step(0, 1, 1, 32'hD, 0);
        chk("flush_data", out_data, RV);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

        // Stall counter saturation, survives flush, cleared by reset
        step(0, 0, 1, 32'h7, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 150) == 0, ($urandom % 40) == 0, $urandom % 2 == 1,
                 $urandom, ($urandom % 10) < 7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
